// File: rtl/riscv_bpred_gshare_ras.sv
`default_nettype none
// ============================================================================
// Module   : riscv_bpred_gshare_ras
// Purpose  : Next-fetch-PC predictor: gshare BHT, typed fully-associative BTB
//            and checkpointed return address stack.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_bpred_gshare_ras #(
    parameter  int FETCH_W = 2,
    parameter  int NUM_BHT = 512,
    parameter  int GHR_W   = 8,
    parameter  int NUM_BTB = 32,
    parameter  int NUM_RAS = 8,
    localparam int SLOT_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
    localparam int RAS_W   = $clog2(NUM_RAS)
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic [31:0]       fetch_pc,
    input  logic              fetch_accept,
    output logic [31:0]       pc_next,
    output logic              pred_taken,
    output logic [SLOT_W-1:0] pred_slot,
    output logic [GHR_W-1:0]  pred_ghr,
    output logic [RAS_W-1:0]  pred_ras_ptr,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              br_taken,
    input  logic [31:0]       br_src,
    input  logic [31:0]       br_target,
    input  logic [GHR_W-1:0]  br_ghr,
    input  logic [RAS_W-1:0]  br_ras_ptr,
    input  logic              br_mispredict
);

    localparam int OFF_W = $clog2(FETCH_W) + 2;
    localparam int BHT_W = $clog2(NUM_BHT);
    localparam int BTB_W = $clog2(NUM_BTB);
    localparam int CNT_W = RAS_W + 1;

    localparam logic [1:0] c_type_cond = 2'd0;
    localparam logic [1:0] c_type_call = 2'd2;
    localparam logic [1:0] c_type_ret  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_bht      [NUM_BHT];
    logic             r_btb_vld  [NUM_BTB];
    logic [31:0]      r_btb_src  [NUM_BTB];
    logic [31:0]      r_btb_dst  [NUM_BTB];
    logic [1:0]       r_btb_type [NUM_BTB];
    logic [BTB_W-1:0] r_alloc_ptr;
    logic [GHR_W-1:0] r_ghr;
    logic [31:0]      r_ras      [NUM_RAS];
    logic [RAS_W-1:0] r_ras_ptr;
    logic [CNT_W-1:0] r_ras_cnt;

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [31:0]       w_base;
    logic [SLOT_W-1:0] w_start_slot;
    logic [BHT_W-1:0]  w_ghr_hash;
    logic [FETCH_W-1:0] w_slot_taken;
    logic [FETCH_W-1:0] w_slot_cond;
    logic [31:0]       w_slot_pc   [FETCH_W];
    logic [31:0]       w_slot_dst  [FETCH_W];
    logic [1:0]        w_slot_type [FETCH_W];
    logic              w_unused;

    assign w_base     = {fetch_pc[31:OFF_W], {OFF_W{1'b0}}};
    assign w_ghr_hash = BHT_W'(r_ghr) << (BHT_W - GHR_W);
    assign w_unused   = &{1'b0, fetch_pc[1:0]};

    generate
        if (FETCH_W > 1) begin : g_start_multi
            assign w_start_slot = fetch_pc[OFF_W-1:2];
        end else begin : g_start_single
            assign w_start_slot = '0;
        end
    endgenerate

    generate
        for (genvar s = 0; s < FETCH_W; s++) begin : g_slot
            logic             w_hit;
            logic [1:0]       w_type;
            logic [31:0]      w_dst;
            logic             w_exam;
            logic [BHT_W-1:0] w_idx;

            assign w_slot_pc[s] = w_base + 32'(s * 4);

            // Reverse scan so the lowest matching index is the last writer.
            always_comb begin
                w_hit  = 1'b0;
                w_type = c_type_cond;
                w_dst  = '0;
                for (int e = NUM_BTB - 1; e >= 0; e--) begin
                    if (r_btb_vld[e] && (r_btb_src[e] == w_slot_pc[s])) begin
                        w_hit  = 1'b1;
                        w_type = r_btb_type[e];
                        w_dst  = r_btb_dst[e];
                    end
                end
            end

            assign w_exam          = (SLOT_W'(s) >= w_start_slot);
            assign w_idx           = w_slot_pc[s][BHT_W+1:2] ^ w_ghr_hash;
            assign w_slot_type[s]  = w_type;
            assign w_slot_dst[s]   = w_dst;
            assign w_slot_cond[s]  = w_exam & w_hit & (w_type == c_type_cond);
            assign w_slot_taken[s] = w_exam & w_hit &
                                     ((w_type != c_type_cond) | r_bht[w_idx][1]);
        end
    endgenerate

    logic              w_any_taken;
    logic [SLOT_W-1:0] w_tk_slot;
    logic [1:0]        w_tk_type;
    logic [31:0]       w_tk_pc;
    logic [31:0]       w_tk_dst;
    logic              w_cond_seen;

    // Cond hits up to and including the first taken slot feed the history.
    always_comb begin
        w_any_taken = 1'b0;
        w_tk_slot   = '0;
        w_tk_type   = c_type_cond;
        w_tk_pc     = '0;
        w_tk_dst    = '0;
        w_cond_seen = 1'b0;
        for (int s = 0; s < FETCH_W; s++) begin
            if (!w_any_taken) begin
                if (w_slot_cond[s]) begin
                    w_cond_seen = 1'b1;
                end
                if (w_slot_taken[s]) begin
                    w_any_taken = 1'b1;
                    w_tk_slot   = SLOT_W'(s);
                    w_tk_type   = w_slot_type[s];
                    w_tk_pc     = w_slot_pc[s];
                    w_tk_dst    = w_slot_dst[s];
                end
            end
        end
    end

    logic w_ras_nonempty;
    assign w_ras_nonempty = (r_ras_cnt != '0);

    always_comb begin
        pc_next = w_base + 32'(FETCH_W * 4);
        if (w_any_taken) begin
            if ((w_tk_type == c_type_ret) && w_ras_nonempty) begin
                pc_next = r_ras[r_ras_ptr];
            end else begin
                pc_next = w_tk_dst;
            end
        end
    end

    assign pred_taken   = w_any_taken;
    assign pred_slot    = w_tk_slot;
    assign pred_ghr     = r_ghr;
    assign pred_ras_ptr = r_ras_ptr;

    // ------------------------------------------------------------------
    // Speculative GHR / RAS next state (redirect beats accept)
    // ------------------------------------------------------------------
    logic             w_redirect;
    logic [RAS_W-1:0] w_ras_base;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_push_addr;
    logic [GHR_W-1:0] w_ghr_next;
    logic [RAS_W-1:0] w_ras_ptr_next;
    logic [CNT_W-1:0] w_ras_cnt_next;

    assign w_redirect = br_valid & br_mispredict;

    always_comb begin
        w_ras_base  = r_ras_ptr;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_addr = w_tk_pc + 32'd4;
        w_ghr_next  = r_ghr;
        if (w_redirect) begin
            w_ras_base  = br_ras_ptr;
            w_push      = (br_type == c_type_call);
            w_pop       = (br_type == c_type_ret);
            w_push_addr = br_src + 32'd4;
            w_ghr_next  = (br_type == c_type_cond) ?
                          ((br_ghr << 1) | GHR_W'(br_taken)) : br_ghr;
        end else if (fetch_accept) begin
            w_push     = w_any_taken & (w_tk_type == c_type_call);
            w_pop      = w_any_taken & (w_tk_type == c_type_ret) & w_ras_nonempty;
            w_ghr_next = w_cond_seen ?
                         ((r_ghr << 1) | GHR_W'(w_any_taken & (w_tk_type == c_type_cond))) :
                         r_ghr;
        end
    end

    always_comb begin
        w_ras_ptr_next = w_ras_base;
        w_ras_cnt_next = r_ras_cnt;
        if (w_push) begin
            w_ras_ptr_next = w_ras_base + RAS_W'(1);
            if (r_ras_cnt != CNT_W'(NUM_RAS)) begin
                w_ras_cnt_next = r_ras_cnt + CNT_W'(1);
            end
        end else if (w_pop) begin
            w_ras_ptr_next = w_ras_base - RAS_W'(1);
            if (w_ras_nonempty) begin
                w_ras_cnt_next = r_ras_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Resolution-side BTB lookup and BHT index
    // ------------------------------------------------------------------
    logic             w_br_hit;
    logic [BTB_W-1:0] w_br_hit_idx;
    logic [BHT_W-1:0] w_br_idx;

    always_comb begin
        w_br_hit     = 1'b0;
        w_br_hit_idx = '0;
        for (int e = NUM_BTB - 1; e >= 0; e--) begin
            if (r_btb_vld[e] && (r_btb_src[e] == br_src)) begin
                w_br_hit     = 1'b1;
                w_br_hit_idx = BTB_W'(e);
            end
        end
    end

    assign w_br_idx = br_src[BHT_W+1:2] ^ (BHT_W'(br_ghr) << (BHT_W - GHR_W));

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            for (int i = 0; i < NUM_BHT; i++) begin
                r_bht[i] <= 2'b01;
            end
            for (int e = 0; e < NUM_BTB; e++) begin
                r_btb_vld[e] <= 1'b0;
            end
            r_alloc_ptr <= '0;
            r_ghr       <= '0;
            r_ras_ptr   <= '0;
            r_ras_cnt   <= '0;
        end else begin
            if (br_valid && (br_type == c_type_cond)) begin
                if (br_taken && (r_bht[w_br_idx] != 2'b11)) begin
                    r_bht[w_br_idx] <= r_bht[w_br_idx] + 2'b01;
                end else if (!br_taken && (r_bht[w_br_idx] != 2'b00)) begin
                    r_bht[w_br_idx] <= r_bht[w_br_idx] - 2'b01;
                end
            end
            if (br_valid) begin
                if (w_br_hit) begin
                    r_btb_type[w_br_hit_idx] <= br_type;
                    if (br_taken) begin
                        r_btb_dst[w_br_hit_idx] <= br_target;
                    end
                end else if (br_taken) begin
                    r_btb_vld[r_alloc_ptr]  <= 1'b1;
                    r_btb_src[r_alloc_ptr]  <= br_src;
                    r_btb_dst[r_alloc_ptr]  <= br_target;
                    r_btb_type[r_alloc_ptr] <= br_type;
                    r_alloc_ptr             <= r_alloc_ptr + BTB_W'(1);
                end
            end
            r_ghr     <= w_ghr_next;
            r_ras_ptr <= w_ras_ptr_next;
            r_ras_cnt <= w_ras_cnt_next;
            if (w_push) begin
                r_ras[w_ras_ptr_next] <= w_push_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_bpred_gshare_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_bpred_gshare_ras
// Purpose  : Scoreboard bench for riscv_bpred_gshare_ras (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_bpred_gshare_ras;

    logic        clk = 1'b0;
    logic        srst_n;
    logic [31:0] fetch_pc;
    logic        fetch_accept;
    logic [31:0] pc_next;
    logic        pred_taken;
    logic [0:0]  pred_slot;
    logic [7:0]  pred_ghr;
    logic [2:0]  pred_ras_ptr;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        br_taken;
    logic [31:0] br_src;
    logic [31:0] br_target;
    logic [7:0]  br_ghr;
    logic [2:0]  br_ras_ptr;
    logic        br_mispredict;

    riscv_bpred_gshare_ras dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .fetch_pc     (fetch_pc),
        .fetch_accept (fetch_accept),
        .pc_next      (pc_next),
        .pred_taken   (pred_taken),
        .pred_slot    (pred_slot),
        .pred_ghr     (pred_ghr),
        .pred_ras_ptr (pred_ras_ptr),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .br_taken     (br_taken),
        .br_src       (br_src),
        .br_target    (br_target),
        .br_ghr       (br_ghr),
        .br_ras_ptr   (br_ras_ptr),
        .br_mispredict(br_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        tk;
        logic [0:0]  slot;
        logic [7:0]  ghr;
        logic [2:0]  rp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_req = 1'b0;

    // Monitor: pops one expectation per presented lookup.
    always @(negedge clk) begin
        exp_t e;
        if (chk_req) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: lookup presented with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (pc_next !== e.pc || pred_taken !== e.tk || pred_slot !== e.slot ||
                    pred_ghr !== e.ghr || pred_ras_ptr !== e.rp) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h tk=%0d slot=%0d ghr=%h rp=%0d, expected pc=%h tk=%0d slot=%0d ghr=%h rp=%0d",
                             e.name, pc_next, pred_taken, pred_slot, pred_ghr, pred_ras_ptr,
                             e.pc, e.tk, e.slot, e.ghr, e.rp);
                end
            end
        end
    end

    task automatic fetch(input string nm, input logic [31:0] pc, input logic acc,
                         input logic [31:0] epc, input logic etk, input logic [0:0] eslot,
                         input logic [7:0] eghr, input logic [2:0] erp);
        exp_t e;
        e.name = nm; e.pc = epc; e.tk = etk; e.slot = eslot; e.ghr = eghr; e.rp = erp;
        sb.push_back(e);
        fetch_pc     = pc;
        fetch_accept = acc;
        chk_req      = 1'b1;
        @(posedge clk); #1;
        fetch_accept = 1'b0;
        chk_req      = 1'b0;
    endtask

    task automatic set_br(input logic [1:0] t, input logic tk, input logic [31:0] src,
                          input logic [31:0] tgt, input logic [7:0] g, input logic [2:0] rp,
                          input logic mis);
        br_valid = 1'b1; br_type = t; br_taken = tk; br_src = src; br_target = tgt;
        br_ghr = g; br_ras_ptr = rp; br_mispredict = mis;
    endtask

    task automatic clr_br();
        br_valid = 1'b0; br_mispredict = 1'b0;
    endtask

    task automatic resolve(input logic [1:0] t, input logic tk, input logic [31:0] src,
                           input logic [31:0] tgt, input logic [7:0] g, input logic [2:0] rp,
                           input logic mis);
        set_br(t, tk, src, tgt, g, rp, mis);
        @(posedge clk); #1;
        clr_br();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        srst_n = 1'b0; fetch_pc = '0; fetch_accept = 1'b0;
        br_valid = 1'b0; br_type = '0; br_taken = 1'b0; br_src = '0; br_target = '0;
        br_ghr = '0; br_ras_ptr = '0; br_mispredict = 1'b0;
        repeat (3) @(posedge clk);
        #1 srst_n = 1'b1;

        fetch("reset_state", 32'h1004, 0, 32'h1008, 0, 0, 8'h00, 3'd0);

        // Jump via mispredict; taken from slot 1, also with mid-bundle start
        resolve(2'd1, 1, 32'h2004, 32'h3000, 8'h00, 3'd0, 1);
        fetch("jump_slot1", 32'h2000, 0, 32'h3000, 1, 1, 8'h00, 3'd0);
        fetch("jump_midbundle_acc", 32'h2004, 1, 32'h3000, 1, 1, 8'h00, 3'd0);

        // Conditional training and saturation
        resolve(2'd0, 1, 32'h4000, 32'h4100, 8'h00, 3'd0, 0);
        resolve(2'd0, 1, 32'h4000, 32'h4100, 8'h00, 3'd0, 0);
        fetch("cond_taken", 32'h4000, 0, 32'h4100, 1, 0, 8'h00, 3'd0);
        resolve(2'd0, 0, 32'h6000, 32'h6100, 8'h80, 3'd0, 0);
        fetch("nt_miss_no_alloc", 32'h6000, 0, 32'h6008, 0, 0, 8'h00, 3'd0);
        resolve(2'd0, 1, 32'h4000, 32'h4100, 8'h00, 3'd0, 0);
        resolve(2'd0, 0, 32'h4000, 32'h4999, 8'h00, 3'd0, 0);
        fetch("cond_sat_hi", 32'h4000, 0, 32'h4100, 1, 0, 8'h00, 3'd0);
        resolve(2'd0, 0, 32'h4000, 32'h4999, 8'h00, 3'd0, 0);
        fetch("cond_weak_nt", 32'h4000, 0, 32'h4008, 0, 0, 8'h00, 3'd0);
        resolve(2'd0, 1, 32'h4000, 32'h4100, 8'h00, 3'd0, 0);
        fetch("cond_accept", 32'h4000, 1, 32'h4100, 1, 0, 8'h00, 3'd0);
        fetch("ghr_shifted", 32'h1004, 0, 32'h1008, 0, 0, 8'h01, 3'd0);
        fetch("ghr_hash_idx", 32'h4000, 0, 32'h4008, 0, 0, 8'h01, 3'd0);

        // Call / return
        resolve(2'd2, 1, 32'h5000, 32'h7000, 8'h00, 3'd0, 0);
        resolve(2'd3, 1, 32'h7000, 32'h7777, 8'h00, 3'd0, 0);
        fetch("ret_empty_acc", 32'h7000, 1, 32'h7777, 1, 0, 8'h01, 3'd0);
        fetch("call_push", 32'h5000, 1, 32'h7000, 1, 0, 8'h01, 3'd0);
        fetch("ret_pop", 32'h7000, 1, 32'h5004, 1, 0, 8'h01, 3'd1);
        fetch("ret_after_pop", 32'h7000, 0, 32'h7777, 1, 0, 8'h01, 3'd0);

        // RAS overflow: nine calls, eight returns newest-first
        for (int k = 0; k < 9; k++)
            resolve(2'd2, 1, 32'h8000 + 32'(k) * 16, 32'h9000 + 32'(k) * 16, 8'h00, 3'd0, 0);
        for (int k = 0; k < 9; k++)
            fetch($sformatf("ovf_call_%0d", k), 32'h8000 + 32'(k) * 16, 1,
                  32'h9000 + 32'(k) * 16, 1, 0, 8'h01, 3'(k));
        for (int j = 0; j < 8; j++)
            fetch($sformatf("ovf_ret_%0d", j), 32'h7000, 1,
                  32'h8004 + 32'(8 - j) * 16, 1, 0, 8'h01, 3'(1 - j));
        fetch("ovf_drained", 32'h7000, 0, 32'h7777, 1, 0, 8'h01, 3'd1);

        // Same-cycle accept and mispredict: redirect wins
        set_br(2'd0, 1, 32'hA000, 32'hA100, 8'h05, 3'd3, 1);
        fetch("accept_plus_mispred", 32'h5000, 1, 32'h7000, 1, 0, 8'h01, 3'd1);
        clr_br();
        fetch("mispred_ghr_0b", 32'h1004, 0, 32'h1008, 0, 0, 8'h0B, 3'd3);

        // Mispredicted call pushes, mispredicted ret pops
        resolve(2'd2, 1, 32'hB000, 32'hB100, 8'h20, 3'd3, 1);
        fetch("mispred_call_push", 32'h7000, 0, 32'hB004, 1, 0, 8'h20, 3'd4);
        resolve(2'd3, 1, 32'h7000, 32'hB004, 8'h21, 3'd4, 1);
        fetch("mispred_ret_pop", 32'h7000, 0, 32'hB004, 1, 0, 8'h21, 3'd3);

        // Mid-run reset clears everything
        srst_n = 1'b0;
        @(posedge clk); #1;
        srst_n = 1'b1;
        fetch("mid_reset", 32'h7000, 0, 32'h7008, 0, 0, 8'h00, 3'd0);

        repeat (2) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
